// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider for unsigned operands.
// A start/done handshake takes a dividend and a divisor. Quotient and remainder
// come back after WIDTH iterations. Each iteration uses the shared subtract
// datapath (x + ~y + 1); a carry-out of 1 means the subtraction did not borrow.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst          synchronous active-high reset
//   start        request a divide (accepted in IDLE or DONE only)
//   x, y         dividend / divisor, captured when start is accepted
//   busy         high while iterations are in progress
//   done         one-cycle pulse: q, r and div_by_zero are valid
//   q, r         quotient / remainder, held until the next completion
//   div_by_zero  set together with done when the captured divisor was 0
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned TW = WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] p, p_n;        // partial remainder, always < divisor between iterations
  logic [WIDTH-1:0] a, a_n;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d, d_n;        // captured divisor
  logic [CW-1:0]    cnt, cnt_n;
  logic             busy_n, done_n, dbz_n;
  logic [WIDTH-1:0] q_n, r_n;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] a_sh;
  logic [TW-1:0]    trial;
  logic             no_borrow;
  logic             trial_msb_unused;

  // Shift {P,A} left and form the trial subtraction P - {0,Y}.
  always_comb begin
    p_sh             = {p, a[WIDTH-1]};
    a_sh             = a << 1;
    trial            = {1'b0, p_sh} + {1'b0, ~{1'b0, d}} + TW'(1);
    no_borrow        = trial[TW-1];
    // A kept trial is below the divisor, so this bit is zero whenever it is used.
    trial_msb_unused = trial[WIDTH];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    p_n     = p;
    a_n     = a;
    d_n     = d;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    q_n     = q;
    r_n     = r;
    dbz_n   = div_by_zero;
    case (state)
      RUN: begin
        a_n   = a_sh | WIDTH'(no_borrow);
        p_n   = no_borrow ? trial[WIDTH-1:0] : p_sh[WIDTH-1:0];
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          q_n     = a_n;
          r_n     = p_n;
          dbz_n   = 1'b0;
        end
      end
      IDLE, DONE: begin
        // DONE lasts one cycle; a start here gives back-to-back operation.
        state_n = IDLE;
        if (start) begin
          d_n   = y;
          cnt_n = '0;
          if (y != '0) begin
            state_n = RUN;
            p_n     = '0;
            a_n     = x;
            busy_n  = 1'b1;
          end else begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            q_n     = '1;
            r_n     = x;
            dbz_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      p           <= '0;
      a           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      p           <= p_n;
      a           <= a_n;
      d           <= d_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      q           <= q_n;
      r           <= r_n;
      div_by_zero <= dbz_n;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (WIDTH=4).
// Expected results go into a scoreboard queue when an operation is started.
// A monitor pops one entry on every done pulse and compares it with the outputs.
module tb_seq_divider;

  localparam int unsigned WIDTH   = 4;
  localparam int          MAXWAIT = 20;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [WIDTH-1:0] x, y, q, r;
  logic             busy, done, div_by_zero;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .x           (x),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    res_t             exp;
  } vec_t;

  res_t sb[$];
  res_t mon_exp;
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic res_t mk_res(input int qv, input int rv, input int dv);
    res_t t;
    t.q   = WIDTH'(qv);
    t.r   = WIDTH'(rv);
    t.dbz = 1'(dv);
    return t;
  endfunction

  function automatic vec_t mk_vec(input int xv, input int yv, input int qv, input int rv, input int dv);
    vec_t v;
    v.x   = WIDTH'(xv);
    v.y   = WIDTH'(yv);
    v.exp = mk_res(qv, rv, dv);
    return v;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, plus the busy/done exclusivity check.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_exp = sb.pop_front();
          check("result_q_r_dbz", 32'({q, r, div_by_zero}), 32'(mon_exp));
        end
      end
    end
  end

  // One complete operation: start, latency and busy count, then the end of the done pulse.
  task automatic run_op(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                        input res_t e, output res_t got);
    int lat;
    int busy_cnt;
    start = 1'b1;
    x     = xv;
    y     = yv;
    sb.push_back(e);
    tick();
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < MAXWAIT) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check("latency", 32'(lat), (yv == '0) ? 32'd0 : 32'(WIDTH));
    check("busy_cycles", 32'(busy_cnt), (yv == '0) ? 32'd0 : 32'(WIDTH));
    if (!done) sb.delete();
    got = {q, r, div_by_zero};
    tick();
    check("done_single_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    res_t got;
    res_t e;
    int   lat;
    int   gq, gr;

    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);

    // Directed vectors: {x, y, q, r, div_by_zero}.
    tbl[0] = mk_vec(13, 4, 3, 1, 0);
    tbl[1] = mk_vec(15, 1, 15, 0, 0);
    tbl[2] = mk_vec(7, 9, 0, 7, 0);
    tbl[3] = mk_vec(0, 5, 0, 0, 0);
    tbl[4] = mk_vec(15, 15, 1, 0, 0);
    tbl[5] = mk_vec(9, 0, 15, 9, 1);
    tbl[6] = mk_vec(6, 3, 2, 0, 0);
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].x, tbl[i].y, tbl[i].exp, got);
    end

    // A start during RUN must be ignored.
    sb.push_back(mk_res(3, 1, 0));
    start = 1'b1; x = 4'd13; y = 4'd4;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; x = 4'd2; y = 4'd1;
    tick();
    start = 1'b0; x = '0; y = '0;
    lat = 2;
    while (!done && lat < MAXWAIT) begin
      tick();
      lat++;
    end
    check("ignored_start_latency", 32'(lat), 32'(WIDTH));
    tick();
    check("ignored_start_pulse", 32'(done), 32'd0);

    // Reset at E2 of a running operation discards it.
    start = 1'b1; x = 4'd13; y = 4'd4;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_q", 32'(q), 32'd0);
    check("midrst_r", 32'(r), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    repeat (WIDTH + 2) begin
      tick();
      check("midrst_no_done", 32'(done), 32'd0);
    end
    run_op(4'd10, 4'd3, mk_res(3, 1, 0), got);

    // Back-to-back: the second start is accepted in the DONE cycle.
    sb.push_back(mk_res(5, 1, 0));
    start = 1'b1; x = 4'd11; y = 4'd2;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < MAXWAIT) begin
      tick();
      lat++;
    end
    check("b2b_first_latency", 32'(lat), 32'(WIDTH));
    sb.push_back(mk_res(2, 4, 0));
    start = 1'b1; x = 4'd14; y = 4'd5;
    tick();
    start = 1'b0;
    check("b2b_busy_no_gap", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < MAXWAIT) begin
      tick();
      lat++;
    end
    check("b2b_done_spacing", 32'(lat), 32'(WIDTH + 1));
    tick();
    check("b2b_done_pulse", 32'(done), 32'd0);

    // Exhaustive sweep against the reference model, plus the division identity.
    for (int xi = 0; xi < (1 << WIDTH); xi++) begin
      for (int yi = 0; yi < (1 << WIDTH); yi++) begin
        if (yi == 0) e = mk_res((1 << WIDTH) - 1, xi, 1);
        else         e = mk_res(xi / yi, xi % yi, 0);
        run_op(WIDTH'(xi), WIDTH'(yi), e, got);
        if (yi != 0) begin
          gq = int'(got.q);
          gr = int'(got.r);
          check("sweep_identity", 32'((gq * yi + gr == xi) && (gr < yi)), 32'd1);
        end
      end
    end

    tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
